piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready handshake and drives it out one bit per clock on a serial line.
- Serves as the transmit end of the lab's serial data path. Its matching receive end is a capture element with preset/clear that rebuilds the word from the bit stream.
- Control style matches the lab's storage elements: an asynchronous clear plus a synchronous preset that forces the line to its idle-high level.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- clear_n  input  1  asynchronous, active-low reset.
- preset  input  1  synchronous, active-high abort; forces the line idle-high.
- load  input  1  word valid; the word is accepted when load && ready at a rising edge.
- din  input  WIDTH  parallel word; sampled only on acceptance.
- ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data; idle level is 1.
- sout_valid  output  1  sout carries a data bit this cycle.
- last  output  1  the current bit is the final bit of the word.
- busy  output  1  a word is being shifted.

Behaviour:
- clear_n low (asynchronous, at any time): state=IDLE, shift register=0, bit counter=0, sout=1, sout_valid=0, last=0, busy=0, ready=1.
  - Applies mid-word: the word is discarded and nothing resumes after release.
- Control priority at each rising edge: clear_n, then preset, then the load handshake, then shifting.
- States:
  - IDLE: ready=1, busy=0, sout=1, sout_valid=0.
  - SHIFT: busy=1, sout_valid=1.
- IDLE -> SHIFT on load && ready:
  - Capture din into the shift register and set counter=0.
  - The first bit appears on sout in the cycle after the accepting edge, so latency is 1 cycle.
- SHIFT operation:
  - One bit is presented per cycle; the counter increments every edge.
  - Bit order follows MSB_FIRST.
  - When counter == WIDTH-1: last=1, and ready=1 (early ready).
- End of word (the edge at counter == WIDTH-1):
  - With load: capture the new din, reset the counter to 0, stay in SHIFT. Words stream back-to-back with no gap cycle.
  - Without load: go to IDLE; sout returns to 1 and sout_valid to 0.
- ready=0 during SHIFT except on the last-bit cycle. load while ready=0 is ignored, and din is not sampled.
- preset=1 at an edge in any state:
  - Go to IDLE; sout=1, sout_valid=0, last=0, counter=0.
  - Any in-flight word is dropped.
  - A load in the same cycle is ignored.
- Each word occupies exactly WIDTH consecutive sout_valid cycles.
- Counter width is clog2(WIDTH); it never exceeds WIDTH-1.
- All outputs are registered or decoded from state/counter only; there is no combinational path from load/din to the outputs.

Test Plan:
- Reset and idle: clear_n=0 for 2 cycles, then release with load=0 for 5 cycles -> sout=1, sout_valid=0, ready=1, busy=0, last=0 throughout.
- MSB-first word: WIDTH=8, MSB_FIRST=1, load 8'h01 for one cycle -> sout = 0,0,0,0,0,0,0,1 over cycles 1..8; last only on cycle 8; ready=1 on cycle 8; back in IDLE on cycle 9.
- LSB-first word: MSB_FIRST=0, load 8'h01 -> sout = 1,0,0,0,0,0,0,0; last on bit 8.
- Back-to-back and ignored load:
  - Load 8'hA5, then hold load=1 with din=8'h3C -> 16 contiguous sout_valid cycles, MSB-first 10100101 then 00111100; last high on cycles 8 and 16.
  - A mid-word load with din=8'hFF (ready=0) -> ignored; the bit stream is unchanged.
- preset abort: preset=1 for 1 cycle during bit 4 of 8'hA5, with load=1 in the same cycle -> next cycle sout=1, sout_valid=0, ready=1, busy=0; no word is accepted.
- Async clear: drop clear_n between edges during bit 3 -> outputs take reset values immediately, before the next edge; after release, the first load of 8'hF0 shifts 11110000 cleanly.

Source files
------------

// File: rtl/piso_if.sv
// Parallel-word handshake plus serial output bundle for piso_serializer.
// The producer side (master) drives load/din and observes the line.
interface piso_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;

  modport master (
    output load, din,
    input  ready, sout, sout_valid, last, busy
  );

  modport slave (
    input  load, din,
    output ready, sout, sout_valid, last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with async clear and sync preset.
// Outputs decode from state/counter/shift register only.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic  clk,
  input  logic  clear_n,
  input  logic  preset,
  piso_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  logic shifting;
  logic at_end;
  logic rdy;
  logic accept;
  logic do_abort;
  logic do_load;
  logic do_step;
  logic out_bit;

  assign shifting = (state_q == SHIFT);
  assign at_end   = shifting && (cnt_q == CMAX);
  assign rdy      = !shifting || at_end;
  assign accept   = bus.load && rdy;

  assign do_abort = preset;
  assign do_load  = !preset && accept;
  assign do_step  = !preset && !accept && shifting;

  assign out_bit  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

  assign bus.ready      = rdy;
  assign bus.busy       = shifting;
  assign bus.sout_valid = shifting;
  assign bus.last       = at_end;
  assign bus.sout       = shifting ? out_bit : 1'b1;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    unique case (1'b1)
      do_abort: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      do_load: begin
        state_d = SHIFT;
        cnt_d   = '0;
        sreg_d  = bus.din;
      end
      // last bit with no follow-on word: drop back to idle
      do_step: begin
        if (at_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances driven together,
// checked against a queue-of-bits reference model plus fixed vectors.
module tb_piso_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic clear_n;
  logic preset;

  int checks = 0;
  int errors = 0;

  bit qm[$];
  bit ql[$];

  piso_if #(.WIDTH(W)) bm ();
  piso_if #(.WIDTH(W)) bl ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (
    .clk     (clk),
    .clear_n (clear_n),
    .preset  (preset),
    .bus     (bm.slave)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (
    .clk     (clk),
    .clear_n (clear_n),
    .preset  (preset),
    .bus     (bl.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] d;
    logic       e_m;
    logic       e_l;
    logic       e_v;
    logic       e_last;
    logic       e_rdy;
  } vec_t;

  vec_t tbl[9];

  task automatic cmp(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic ld, input logic [7:0] d,
                            input logic pr);
    if (!clear_n || pr) begin
      qm.delete();
      ql.delete();
    end else if (ld && qm.size() <= 1) begin
      qm.delete();
      ql.delete();
      for (int i = 0; i < W; i++) begin
        qm.push_back(d[W-1-i]);
        ql.push_back(d[i]);
      end
    end else if (qm.size() > 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
  endtask

  task automatic check_model();
    logic bz;
    bz = (qm.size() > 0);
    cmp("m.sout",  bm.sout,       bz ? logic'(qm[0]) : 1'b1);
    cmp("m.valid", bm.sout_valid, bz);
    cmp("m.busy",  bm.busy,       bz);
    cmp("m.last",  bm.last,       qm.size() == 1);
    cmp("m.ready", bm.ready,      qm.size() <= 1);
    bz = (ql.size() > 0);
    cmp("l.sout",  bl.sout,       bz ? logic'(ql[0]) : 1'b1);
    cmp("l.valid", bl.sout_valid, bz);
    cmp("l.busy",  bl.busy,       bz);
    cmp("l.last",  bl.last,       ql.size() == 1);
    cmp("l.ready", bl.ready,      ql.size() <= 1);
  endtask

  task automatic cyc(input logic ld, input logic [7:0] d, input logic pr);
    bm.load = ld;
    bl.load = ld;
    bm.din  = d;
    bl.din  = d;
    preset  = pr;
    @(posedge clk);
    model_edge(ld, d, pr);
    @(negedge clk);
    check_model();
  endtask

  task automatic check_idle(input string nm);
    cmp({nm, ".sout"},  bm.sout,       1'b1);
    cmp({nm, ".valid"}, bm.sout_valid, 1'b0);
    cmp({nm, ".ready"}, bm.ready,      1'b1);
    cmp({nm, ".busy"},  bm.busy,       1'b0);
    cmp({nm, ".last"},  bm.last,       1'b0);
  endtask

  initial begin
    int nv;
    int nl;

    tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[0].e_m = 1'b0;

    clear_n = 1'b0;
    preset  = 1'b0;
    bm.load = 1'b0;
    bl.load = 1'b0;
    bm.din  = '0;
    bl.din  = '0;

    // reset and idle
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check_idle("rst");
    clear_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      check_idle("idle");
    end

    // 8'h01 both orders, with an ignored mid-word load of 8'hFF
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].ld, tbl[i].d, 1'b0);
      cmp("v.m.sout", bm.sout,       tbl[i].e_m);
      cmp("v.l.sout", bl.sout,       tbl[i].e_l);
      cmp("v.valid",  bm.sout_valid, tbl[i].e_v);
      cmp("v.last",   bm.last,       tbl[i].e_last);
      cmp("v.ready",  bm.ready,      tbl[i].e_rdy);
    end

    // back-to-back A5 then 3C
    nv = 0;
    nl = 0;
    cyc(1'b1, 8'hA5, 1'b0);
    nv += int'(bm.sout_valid);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h3C, 1'b0);
      nv += int'(bm.sout_valid);
      nl += int'(bm.last);
    end
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      nv += int'(bm.sout_valid);
      nl += int'(bm.last);
    end
    cmp("b2b.nvalid16", nv == 16, 1'b1);
    cmp("b2b.nlast2",   nl == 2,  1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    check_idle("b2b.end");

    // preset abort during bit 4 with a simultaneous load
    cyc(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1);
    check_idle("preset");
    cyc(1'b0, 8'h00, 1'b0);
    check_idle("preset.after");

    // async clear between edges during bit 3
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    #2;
    clear_n = 1'b0;
    #1;
    qm.delete();
    ql.delete();
    check_idle("aclr");
    check_model();
    cyc(1'b0, 8'h00, 1'b0);
    clear_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    check_idle("aclr.rel");
    for (int i = 0; i < 8; i++) begin
      cyc(i == 0, 8'hF0, 1'b0);
      cmp("f0.bit", bm.sout, i < 4);
    end
    cyc(1'b0, 8'h00, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 3) != 0, 8'($urandom), ($urandom % 23) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
